ram_scan_reader: RTL and testbench

//  Automatic read-side sequencer for the 32x4 switch-loaded display RAM.

---
 rtl/ram_scan_reader.sv | 96 +++++++++
 tb/tb_ram_scan_reader.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_scan_reader.sv
// Read-side sequencer for the switch-loaded display RAM: walks every address,
// captures each returned word and holds the address/data pair for the HEX decoders.
module ram_scan_reader #(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 4,
  parameter int DWELL      = 50000000,
  parameter bit CONTINUOUS = 1'b0
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  input  logic              pause,
  output logic [ADDR_W-1:0] rd_address,
  output logic              rd_wren,
  input  logic [DATA_W-1:0] rd_q,
  output logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = (DWELL > 2) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DWELL - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

  typedef enum logic [2:0] {
    IDLE, ISSUE, CAPTURE, DWELL_ST, FINISH
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // The read port is only ever read from here; writes come from the switch side.
  assign rd_wren = 1'b0;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      rd_address <= '0;
      disp_addr  <= '0;
      disp_data  <= '0;
      disp_valid <= 1'b0;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            rd_address <= '0;
            busy       <= 1'b1;
            state      <= ISSUE;
          end
        end
        // RAM registers rd_address on this edge; rd_q is valid in CAPTURE.
        ISSUE: state <= CAPTURE;
        CAPTURE: begin
          disp_data  <= rd_q;
          disp_addr  <= rd_address;
          disp_valid <= 1'b1;
          cnt        <= '0;
          state      <= DWELL_ST;
        end
        DWELL_ST: begin
          if (!pause) begin
            if (cnt == CNT_LAST) begin
              if (rd_address != ADDR_LAST) begin
                rd_address <= rd_address + 1'b1;
                state      <= ISSUE;
              end else if (CONTINUOUS) begin
                rd_address <= '0;
                state      <= ISSUE;
              end else begin
                done  <= 1'b1;
                state <= FINISH;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_scan_reader.sv
// Scoreboard bench for ram_scan_reader: stimulus queues expected captures,
// monitors pop them whenever the display pair changes.
module tb_ram_scan_reader;

  localparam int AW = 5;
  localparam int DW = 4;
  localparam int DWELL = 4;
  localparam int PERIOD = DWELL + 2;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0, pause = 1'b0;
  logic          start_c = 1'b0;
  logic [AW-1:0] rd_address, disp_addr, rd_address_c, disp_addr_c;
  logic [DW-1:0] rd_q, disp_data, rd_q_c, disp_data_c;
  logic          rd_wren, disp_valid, busy, done;
  logic          rd_wren_c, disp_valid_c, busy_c, done_c;

  logic [DW-1:0] mem [32];

  int total = 0;
  int bad = 0;

  logic [AW+DW-1:0] exp_q[$];
  int  cyc = 0;
  int  done_cnt = 0;
  int  p5_cnt = 0;
  int  wren_hi = 0;
  bit  per_chk = 1'b0;
  int  last_cap = -1;

  int  c_exp = 0;
  int  c_caps = 0;
  int  c_done = 0;
  int  c_busy_lo = 0;
  bit  c_run = 1'b0;

  always #5 clock = ~clock;

  ram_scan_reader #(.ADDR_W(AW), .DATA_W(DW), .DWELL(DWELL), .CONTINUOUS(1'b0)) dut (
    .clock(clock), .resetn(resetn), .start(start), .pause(pause),
    .rd_address(rd_address), .rd_wren(rd_wren), .rd_q(rd_q),
    .disp_addr(disp_addr), .disp_data(disp_data), .disp_valid(disp_valid),
    .busy(busy), .done(done)
  );

  ram_scan_reader #(.ADDR_W(AW), .DATA_W(DW), .DWELL(DWELL), .CONTINUOUS(1'b1)) dutc (
    .clock(clock), .resetn(resetn), .start(start_c), .pause(1'b0),
    .rd_address(rd_address_c), .rd_wren(rd_wren_c), .rd_q(rd_q_c),
    .disp_addr(disp_addr_c), .disp_data(disp_data_c), .disp_valid(disp_valid_c),
    .busy(busy_c), .done(done_c)
  );

  // Synchronous-read RAM models: word appears the cycle after the address is clocked.
  always @(posedge clock) begin
    rd_q   <= mem[rd_address];
    rd_q_c <= mem[rd_address_c];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [AW+DW-1:0] pair(input int a);
    logic [DW-1:0] d;
    d = DW'(a) ^ 4'hA;
    return {AW'(a), d};
  endfunction

  task automatic push_scan();
    for (int a = 0; a < 32; a++) exp_q.push_back(pair(a));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int i;
    i = 0;
    while (!done && i < budget) begin
      @(negedge clock);
      i++;
    end
    chk(name, {31'd0, done}, 32'd1);
  endtask

  task automatic wait_addr(input string name, input logic [AW-1:0] a, input int budget);
    int i;
    i = 0;
    while (!(disp_valid && disp_addr == a) && i < budget) begin
      @(negedge clock);
      i++;
    end
    chk(name, {27'd0, disp_addr}, {27'd0, a});
  endtask

  // Main monitor: a capture is any change of the displayed pair while valid.
  initial begin
    bit pv;
    logic [AW+DW-1:0] prev, got, e;
    pv = 1'b0;
    prev = '0;
    forever begin
      @(negedge clock);
      cyc++;
      if (rd_wren !== 1'b0 || rd_wren_c !== 1'b0) wren_hi++;
      if (!resetn) begin
        pv = 1'b0;
      end else begin
        got = {disp_addr, disp_data};
        if (disp_valid && (!pv || got != prev)) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_capture", {23'd0, got}, 32'h1ff);
          end else begin
            e = exp_q.pop_front();
            chk("capture_pair", {23'd0, got}, {23'd0, e});
            if (per_chk && disp_addr != 0 && last_cap >= 0)
              chk("addr_period", cyc - last_cap, PERIOD);
          end
          last_cap = cyc;
        end
        pv = disp_valid;
        prev = got;
        if (done) done_cnt++;
        if (disp_addr == 5 && rd_address == 5 && busy) p5_cnt++;
      end
    end
  end

  // Continuous-mode monitor: addresses must run 0..31 and wrap back to 0.
  initial begin
    bit pv;
    logic [AW+DW-1:0] prev, got;
    pv = 1'b0;
    prev = '0;
    forever begin
      @(negedge clock);
      if (!resetn) begin
        pv = 1'b0;
      end else begin
        got = {disp_addr_c, disp_data_c};
        if (disp_valid_c && (!pv || got != prev)) begin
          chk("cont_pair", {23'd0, got}, {23'd0, pair(c_exp)});
          c_exp = (c_exp + 1) % 32;
          c_caps++;
        end
        pv = disp_valid_c;
        prev = got;
        if (done_c) c_done++;
        if (c_run && !busy_c) c_busy_lo++;
      end
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = DW'(i) ^ 4'hA;

    // Reset state
    #1;
    chk("rst_rd_address", {27'd0, rd_address}, 0);
    chk("rst_disp_valid", {31'd0, disp_valid}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    repeat (2) @(negedge clock);

    // 1: full scan, latency, period, single done
    per_chk = 1'b1;
    last_cap = -1;
    push_scan();
    pulse_start();
    chk("t1_busy_after_start", {31'd0, busy}, 1);
    @(negedge clock);
    chk("t1_valid_before_3", {31'd0, disp_valid}, 0);
    @(negedge clock);
    chk("t1_valid_at_3", {31'd0, disp_valid}, 1);
    wait_done("t1_done_seen", 400);
    chk("t1_done_addr", {27'd0, disp_addr}, 31);
    @(negedge clock);
    chk("t1_busy_after_done", {31'd0, busy}, 0);
    chk("t1_done_one_cycle", {31'd0, done}, 0);
    chk("t1_valid_kept", {31'd0, disp_valid}, 1);
    repeat (10) @(negedge clock);
    chk("t1_done_count", done_cnt, 1);
    chk("t1_queue_empty", exp_q.size(), 0);
    per_chk = 1'b0;

    // 2: reset mid-dwell at address 10
    push_scan();
    pulse_start();
    wait_addr("t2_reach_10", 10, 200);
    @(negedge clock);
    resetn = 1'b0;
    #1;
    chk("t2_rd_address", {27'd0, rd_address}, 0);
    chk("t2_disp_addr", {27'd0, disp_addr}, 0);
    chk("t2_disp_data", {28'd0, disp_data}, 0);
    chk("t2_disp_valid", {31'd0, disp_valid}, 0);
    chk("t2_busy", {31'd0, busy}, 0);
    exp_q.delete();
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    repeat (20) @(negedge clock);
    chk("t2_idle_busy", {31'd0, busy}, 0);
    chk("t2_idle_valid", {31'd0, disp_valid}, 0);
    chk("t2_done_count", done_cnt, 1);

    // 3: pause 20 cycles at address 5
    p5_cnt = 0;
    push_scan();
    pulse_start();
    wait_addr("t3_reach_5", 5, 100);
    pause = 1'b1;
    repeat (20) @(negedge clock);
    pause = 1'b0;
    wait_done("t3_done_seen", 400);
    chk("t3_hold_at_5", p5_cnt, 24);
    @(negedge clock);
    chk("t3_queue_empty", exp_q.size(), 0);

    // 5: start ignored while busy; start held through FINISH restarts
    per_chk = 1'b1;
    last_cap = -1;
    push_scan();
    push_scan();
    pulse_start();
    wait_addr("t5_reach_3", 3, 100);
    pulse_start();
    wait_addr("t5_reach_31", 31, 400);
    start = 1'b1;
    wait_done("t5_done1", 40);
    @(negedge clock);
    chk("t5_idle_gap", {31'd0, busy}, 0);
    @(negedge clock);
    chk("t5_restart_busy", {31'd0, busy}, 1);
    chk("t5_restart_addr", {27'd0, rd_address}, 0);
    start = 1'b0;
    repeat (3) @(negedge clock);
    wait_done("t5_done2", 400);
    @(negedge clock);
    chk("t5_queue_empty", exp_q.size(), 0);
    chk("t5_done_count", done_cnt, 4);
    per_chk = 1'b0;

    // 4: continuous mode over 70 periods
    start_c = 1'b1;
    @(negedge clock);
    start_c = 1'b0;
    c_run = 1'b1;
    repeat (70 * PERIOD + 4) @(negedge clock);
    chk("t4_captures", {31'd0, c_caps >= 70}, 1);
    chk("t4_wrapped", {31'd0, c_caps > 32}, 1);
    chk("t4_no_done", c_done, 0);
    chk("t4_busy_held", c_busy_lo, 0);

    // 6: write enable never asserted, including through reset
    chk("t6_rd_wren", wren_hi, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
